// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment serial driver.
// Polarity of the encoded frame is selected by SEG_ACTIVE_LOW_EN (see seg_hex_encode).
package seg_pkg;

    localparam int SEG_FRAME_BITS = 64;
    localparam int SEG_DIGITS     = 8;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } seg_state_e;

    // gfedcba, 1 = lit
    localparam logic [6:0] SEG_HEX_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg_hex_encode.sv
// One digit of the frame: {dp, g..a} from a nibble, blank and point flag.
// SEG_ACTIVE_LOW_EN inverts the whole byte for common-anode boards.
module seg_hex_encode
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    input  logic       point_i,
    output logic [7:0] seg_o
);

    logic [7:0] lit;

    always_comb begin
        lit = blank_i ? 8'h00 : {point_i, SEG_HEX_TABLE[nibble_i]};
`ifdef SEG_ACTIVE_LOW_EN
        seg_o = ~lit;
`else
        seg_o = lit;
`endif
    end

endmodule

// File: rtl/seg_serial_driver.sv
// Free-running 8-digit seven-segment frame shifter for a 74HC164 chain.
// Optional SEG_ACTIVE_LOW_EN selects inverted (common-anode) segment polarity.
module seg_serial_driver
    import seg_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] nums,
    input  logic [7:0]  ens,
    input  logic [7:0]  points,
    output logic        SEG_CLK,
    output logic        SEG_DT,
    output logic        busy,
    output logic        frame_done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int BIT_W = $clog2(SEG_FRAME_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SEG_FRAME_BITS - 1);

    logic [SEG_FRAME_BITS-1:0] frame_w;

    for (genvar i = 0; i < SEG_DIGITS; i++) begin : g_digit
        seg_hex_encode u_enc (
            .nibble_i (nums[4*i +: 4]),
            .blank_i  (ens[i]),
            .point_i  (points[i]),
            .seg_o    (frame_w[8*i +: 8])
        );
    end

    seg_state_e                state_q, state_d;
    logic [SEG_FRAME_BITS-1:0] sr_q, sr_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic [DIV_W-1:0]          div_q, div_d;
    logic [GAP_W-1:0]          gap_q, gap_d;
    logic                      clk_q, clk_d;
    logic                      fd_q, fd_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LOAD;
            sr_q    <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            gap_q   <= '0;
            clk_q   <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            gap_q   <= gap_d;
            clk_q   <= clk_d;
            fd_q    <= fd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        div_d   = div_q;
        gap_d   = gap_q;
        clk_d   = clk_q;
        fd_d    = 1'b0;
        case (state_q)
            LOAD: begin
                sr_d    = frame_w;
                bit_d   = BIT_LAST;
                div_d   = DIV_LAST;
                clk_d   = 1'b0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (div_q != '0) begin
                    div_d = div_q - 1'b1;
                end else begin
                    div_d = DIV_LAST;
                    if (!clk_q) begin
                        clk_d = 1'b1;
                    end else begin
                        // end of the high phase: next bit comes up as the clock falls
                        clk_d = 1'b0;
                        sr_d  = sr_q << 1;
                        if (bit_q == '0) begin
                            state_d = GAP;
                            gap_d   = GAP_LAST;
                            fd_d    = 1'b1;
                        end else begin
                            bit_d = bit_q - 1'b1;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - 1'b1;
                end else begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Data is gated by the state so LOAD, GAP and reset always idle at 0.
    assign busy       = (state_q == SHIFT);
    assign SEG_DT     = busy & sr_q[SEG_FRAME_BITS-1];
    assign SEG_CLK    = clk_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_serial_driver.sv
// Bench for seg_serial_driver: default and minimum-parameter instances, frame scoreboard.
module tb_seg_serial_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] nums = '0;
    logic [7:0]  ens = '0;
    logic [7:0]  points = '0;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
            4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
            4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
            4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    function automatic logic [63:0] pol(input logic [63:0] f);
`ifdef SEG_ACTIVE_LOW_EN
        return ~f;
`else
        return f;
`endif
    endfunction

    function automatic logic [63:0] model_frame(input logic [31:0] n, input logic [7:0] e,
                                                input logic [7:0] p);
        logic [63:0] f;
        f = '0;
        for (int i = 0; i < 8; i++)
            f[8*i +: 8] = e[i] ? 8'h00 : {p[i], seg7(n[4*i +: 4])};
        return pol(f);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int D   = (g == 0) ? 4 : 1;
        localparam int G   = (g == 0) ? 16 : 1;
        localparam int PER = 1 + 128 * D + G;

        logic seg_clk, seg_dt, busy_w, fd_w;

        seg_serial_driver #(.CLK_DIV(D), .GAP_CYCLES(G)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .nums       (nums),
            .ens        (ens),
            .points     (points),
            .SEG_CLK    (seg_clk),
            .SEG_DT     (seg_dt),
            .busy       (busy_w),
            .frame_done (fd_w)
        );

        logic [63:0] exp_q[$];
        logic [63:0] cur_exp = '0;
        logic [63:0] cap = '0;
        logic [63:0] last_frame = '0;
        logic        prev_clk = 1'b0;
        logic        e_clk, e_dt, e_busy, e_fd;
        int          cyc = -1;
        int          p = 0;
        int          terr = 0;
        int          last_fd = -1;
        int          nbits = 0;
        int          frames = 0;

        always @(negedge clk) begin
            if (!rst) begin
                if (cyc >= 0) chk($sformatf("timing%0d_rst", g), 64'(terr), 64'd0);
                cyc = -1; terr = 0; last_fd = -1; nbits = 0; prev_clk = 1'b0;
                exp_q.delete();
            end else begin
                cyc++;
                p = cyc % PER;
                if (p == 0) begin
                    cur_exp = model_frame(nums, ens, points);
                    exp_q.push_back(cur_exp);
                end
                e_busy = 1'b0; e_clk = 1'b0; e_dt = 1'b0;
                e_fd   = (p == 128 * D);
                if (p < 128 * D) begin
                    e_busy = 1'b1;
                    e_clk  = (p % (2 * D)) >= D;
                    e_dt   = cur_exp[63 - p / (2 * D)];
                end
                if ({seg_clk, seg_dt, busy_w, fd_w} !== {e_clk, e_dt, e_busy, e_fd}) terr++;
                if (p == PER - 1) begin
                    chk($sformatf("timing%0d", g), 64'(terr), 64'd0);
                    terr = 0;
                end
                if (fd_w) begin
                    if (last_fd >= 0) chk($sformatf("fd_period%0d", g), 64'(cyc - last_fd), 64'(PER));
                    last_fd = cyc;
                end
                if (seg_clk && !prev_clk) begin
                    cap = {cap[62:0], seg_dt};
                    nbits++;
                    if (nbits == 64) begin
                        if (exp_q.size() == 0) chk($sformatf("sb_empty%0d", g), 64'd1, 64'd0);
                        else chk($sformatf("frame%0d", g), cap, exp_q.pop_front());
                        last_frame = cap;
                        frames++;
                        nbits = 0;
                    end
                end
                prev_clk = seg_clk;
            end
        end
    end

    task automatic wait_frames(input int target);
        for (int i = 0; i < 3000 && g_inst[0].frames < target; i++) begin
            @(negedge clk); #1;
        end
        chk("wait_frames", 64'(g_inst[0].frames >= target), 64'd1);
    endtask

    task automatic wait_bits(input int nb);
        for (int i = 0; i < 3000 && g_inst[0].nbits != nb; i++) begin
            @(negedge clk); #1;
        end
        chk("wait_bits", 64'(g_inst[0].nbits), 64'(nb));
    endtask

    logic [63:0] exp64;
    int f;

    initial begin
        repeat (5) @(negedge clk);
        #1;
        chk("rst_out0", 64'({g_inst[0].seg_clk, g_inst[0].seg_dt, g_inst[0].busy_w, g_inst[0].fd_w}), 64'd0);
        chk("rst_out1", 64'({g_inst[1].seg_clk, g_inst[1].seg_dt, g_inst[1].busy_w, g_inst[1].fd_w}), 64'd0);
        @(negedge clk); #1 rst = 1'b1;
        chk("busy_in_load", 64'(g_inst[0].busy_w), 64'd0);
        @(negedge clk); #1;
        chk("busy_rise", 64'(g_inst[0].busy_w), 64'd1);

        wait_frames(2);
        exp64 = pol(64'h3F3F_3F3F_3F3F_3F3F);
        chk("zeros", g_inst[0].last_frame, exp64);
        chk("first8", 64'(g_inst[0].last_frame[63:56]), 64'(exp64[63:56]));

        nums = 32'h1234_5678; ens = 8'h80; points = 8'h01;
        f = g_inst[0].frames;
        wait_frames(f + 2);
        chk("blank_pt", g_inst[0].last_frame, pol(64'h005B_4F66_6D7D_07FF));

        nums = '0; ens = '0; points = '0;
        f = g_inst[0].frames;
        wait_frames(f + 2);
        wait_bits(23);
        nums = 32'hFFFF_FFFF;
        f = g_inst[0].frames;
        wait_frames(f + 1);
        chk("mid_cur", g_inst[0].last_frame, pol(64'h3F3F_3F3F_3F3F_3F3F));
        wait_frames(f + 2);
        chk("mid_next", g_inst[0].last_frame, pol(64'h7171_7171_7171_7171));
        chk("fast_frame", g_inst[1].last_frame, pol(64'h7171_7171_7171_7171));

        wait_bits(44);
        chk("busy_pre_rst", 64'(g_inst[0].busy_w), 64'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst0", 64'({g_inst[0].seg_clk, g_inst[0].seg_dt, g_inst[0].busy_w, g_inst[0].fd_w}), 64'd0);
        chk("mid_rst1", 64'({g_inst[1].seg_clk, g_inst[1].seg_dt, g_inst[1].busy_w, g_inst[1].fd_w}), 64'd0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        f = g_inst[0].frames;
        wait_frames(f + 1);
        chk("post_rst", g_inst[0].last_frame, pol(64'h7171_7171_7171_7171));
        wait_frames(f + 2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/seg_serial_driver.md
# seg_serial_driver

Serial display driver that sits directly downstream of the top-level debug mux on the SWORD-style board. It takes eight hex digits plus per-digit blank and decimal-point masks, encodes them into a 64-bit seven-segment frame, and shifts the frame continuously into the board's 74HC164 chain on `SEG_CLK`/`SEG_DT`. It replaces the ad-hoc shifter that currently sits behind the 8-digit instruction display, and gives the display a defined frame rate and a frame-done strobe.

## Interface
Parameters:
- `CLK_DIV`, default 4: `clk` cycles per `SEG_CLK` half-period, minimum 1.
- `GAP_CYCLES`, default 16: idle `clk` cycles between frames, minimum 1.

Ports:
- `clk`  in  1  system clock. One clock domain only.
- `rst`  in  1  reset, asynchronous assert, active-low (0 = reset).
- `nums`  in  32  eight hex digits; digit i is `nums[4i+3:4i]`.
- `ens`  in  8  per-digit blank mask; `ens[i]=1` blanks digit i, including its point.
- `points`  in  8  per-digit decimal point; `points[i]=1` lights the point of digit i.
- `SEG_CLK`  out  1  shift clock to the 74HC164 chain.
- `SEG_DT`  out  1  serial data, valid across each `SEG_CLK` rising edge.
- `busy`  out  1  high while a frame is being shifted (SHIFT state).
- `frame_done`  out  1  one-cycle pulse after the last bit's high phase.

## Operation
- Digit byte: `{dp, g, f, e, d, c, b, a}`, where 1 means lit.
- Hex encoding (gfedcba): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- Blanked digit: the byte is 0x00 regardless of `nums` and `points`.
- Frame word: `{byte7, byte6, …, byte0}`. Bit 63 is shifted first, so digit 7's dp goes out first.
- FSM has three states: LOAD → SHIFT → GAP → LOAD.
  - LOAD: one cycle. Samples `nums`, `ens` and `points`, encodes them into a 64-bit shift register, and loads the bit counter with 63.
  - SHIFT: for each bit, `SEG_CLK` is low for CLK_DIV cycles with `SEG_DT` = current MSB, then high for CLK_DIV cycles.
    - At the end of the high phase the register shifts left by one and the counter decrements.
    - After bit 0's high phase, go to GAP and pulse `frame_done`.
  - GAP: `SEG_CLK` = 0 and `SEG_DT` = 0 for GAP_CYCLES cycles, then go to LOAD.
- Inputs are sampled only in LOAD. Changes during SHIFT or GAP take effect in the next frame, never mid-frame.
- Free-running: there is no start input, and the first frame begins immediately after reset release.

## Timing
- Reset values: `SEG_CLK=0`, `SEG_DT=0`, `busy=0`, `frame_done=0`. The FSM is in LOAD, the shift register and counters are 0.
- Reset release: LOAD executes in the first `clk` cycle with `rst=1`. `busy` rises in the following cycle.
- `SEG_DT` changes only on the same `clk` edge where `SEG_CLK` goes low (or on SHIFT entry). Each bit therefore has CLK_DIV cycles of setup and CLK_DIV cycles of hold around the rising edge.
- Frame period is 1 + 128·CLK_DIV + GAP_CYCLES cycles; with the defaults that is 529.
- `frame_done` is asserted in the first GAP cycle, for exactly one cycle. `busy` is low in that same cycle.
- Reset asserted mid-frame: the frame is abandoned immediately and the outputs take their reset values. The partial frame is not resumed, and the next frame restarts at bit 63.
- Counter widths must be sized from the parameters with `$clog2`, with no wrap-around inside a phase.

## Configuration
- `SEG_ACTIVE_LOW_EN`:
  - Defined: every frame bit is inverted at encode time (lit = 0), for common-anode boards. Blanked digits become 0xFF.
  - Undefined: lit = 1, as described above.
  - Idle `SEG_DT` in GAP and reset stays 0 in both cases.

## Structure
- `seg_pkg` holds:
  - the state enum (LOAD, SHIFT, GAP);
  - `SEG_FRAME_BITS = 64`;
  - `SEG_DIGITS = 8`;
  - the 16-entry hex-to-segment constant table.
- One combinational sub-module, `seg_hex_encode`. It maps `{nibble, blank, point}` to a byte and applies `SEG_ACTIVE_LOW_EN`. It is instantiated eight times.

## Test plan
- Zeros frame: `nums=0`, `ens=0`, `points=0`, defaults → 64 captured bits equal eight copies of 0x3F, first eight bits 0,0,1,1,1,1,1,1; `frame_done` period 529 cycles.
- Blank and point: `nums=32'h1234_5678`, `ens=8'h80`, `points=8'h01` → byte7=0x00, byte6=0x5B, byte0=0xFF (dp + 7F).
- Mid-frame input change: change `nums` from 0 to 32'hFFFF_FFFF at bit 40 → current frame is all 0x3F, next frame is all 0x71.
- Reset mid-frame: assert `rst=0` during bit 20 → next cycle `SEG_CLK=0`, `SEG_DT=0`, `busy=0`; after release the first captured bit is bit 63 of a fresh frame.
- Parameter sweep: `CLK_DIV=1`, `GAP_CYCLES=1` → `SEG_CLK` toggles every cycle, frame period 130; each `SEG_DT` is stable one cycle either side of the rising edge.
- `SEG_ACTIVE_LOW_EN` defined with the zeros frame → every captured byte is 0xC0; GAP `SEG_DT` is still 0.
